// File: rtl/hazard_pkg.sv
// Shared definitions for the issue-stage hazard unit: opcodes, field
// positions and the per-lane decode record.
package hazard_pkg;

  localparam int INSTR_W = 32;
  localparam int RIDX_W  = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  typedef logic [RIDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t src0;
    reg_idx_t src1;
    logic     src0_vld;
    logic     src1_vld;
    reg_idx_t dst;
    logic     dst_vld;
    logic     is_br;
  } decode_t;

  typedef enum logic {
    SHD_OPEN,
    SHD_SHADOW
  } shd_state_e;

endpackage

// File: rtl/hazard_decode.sv
// Per-lane combinational decoder: extracts source/destination registers
// and the branch flag from a MIPS instruction word. $0 is never reported.
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output decode_t            dec_o
);

  logic [5:0] op;
  reg_idx_t   rs;
  reg_idx_t   rt;
  reg_idx_t   rd;
  logic       use_rs;
  logic       use_rt;

  assign op = instr_i[OP_MSB:OP_LSB];
  assign rs = instr_i[RS_MSB:RS_LSB];
  assign rt = instr_i[RT_MSB:RT_LSB];
  assign rd = instr_i[RD_MSB:RD_LSB];

  // Classify the opcode into operand usage, destination and branch.
  always_comb begin
    dec_o   = '0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    dec_o.src0 = rs;
    dec_o.src1 = rt;
    case (op)
      OP_RTYPE: begin
        use_rs        = 1'b1;
        use_rt        = 1'b1;
        dec_o.dst     = rd;
        dec_o.dst_vld = (rd != '0);
      end
      OP_ADDI, OP_LW: begin
        use_rs        = 1'b1;
        dec_o.dst     = rt;
        dec_o.dst_vld = (rt != '0);
      end
      OP_SW: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        use_rs      = 1'b1;
        use_rt      = 1'b1;
        dec_o.is_br = 1'b1;
      end
      OP_BGTZ: begin
        use_rs      = 1'b1;
        dec_o.is_br = 1'b1;
      end
      default: ;
    endcase
    dec_o.src0_vld = use_rs & (rs != '0);
    dec_o.src1_vld = use_rt & (rt != '0);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard unit: per-register pending-write countdown scoreboard,
// in-order multi-lane issue priority chain and branch-shadow counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int NUM_REGS  = 32,
  parameter int REG_W     = 5,
  parameter int LAT       = 3,
  parameter int BR_SHADOW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [LANES-1:0]   instr_vld,
  input  logic [LANES*32-1:0] instr,
  output logic [LANES-1:0]   issue,
  output logic               stall,
  output logic [NUM_REGS-1:0] busy_regs
);

  localparam int CW  = $clog2(LAT + 1);
  localparam int SHW = (BR_SHADOW > 0) ? $clog2(BR_SHADOW + 1) : 1;

  decode_t          dec [LANES];
  logic [CW-1:0]    cnt_q [NUM_REGS];
  logic [CW-1:0]    cnt_d [NUM_REGS];
  logic [SHW-1:0]   shd_q;
  logic [SHW-1:0]   shd_d;
  shd_state_e       state_q;
  shd_state_e       state_d;
  logic [LANES-1:0] iss;
  logic             br_iss;
  logic             chain;
  logic             br_seen;
  logic             ok;

  for (genvar g = 0; g < LANES; g++) begin : g_dec
    hazard_decode u_dec (
      .instr_i (instr[32*g +: 32]),
      .dec_o   (dec[g])
    );
  end

  // Visibility of which registers still have a write in flight.
  always_comb begin
    busy_regs = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      busy_regs[r] = (cnt_q[r] != '0);
    end
  end

  // In-order issue chain: a lane issues only if every older lane issued,
  // no older lane is a branch, and none of its sources are pending.
  always_comb begin
    iss     = '0;
    br_iss  = 1'b0;
    chain   = rst_n & (state_q == SHD_OPEN);
    br_seen = 1'b0;
    ok      = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      ok = chain & instr_vld[i] & ~br_seen;
      if (dec[i].src0_vld && busy_regs[dec[i].src0[REG_W-1:0]]) ok = 1'b0;
      if (dec[i].src1_vld && busy_regs[dec[i].src1[REG_W-1:0]]) ok = 1'b0;
      for (int unsigned j = 0; j < i; j++) begin
        if (dec[j].dst_vld &&
            ((dec[i].src0_vld && dec[i].src0 == dec[j].dst) ||
             (dec[i].src1_vld && dec[i].src1 == dec[j].dst))) begin
          ok = 1'b0;
        end
      end
      iss[i]  = ok;
      chain   = ok;
      br_iss  = br_iss | (ok & dec[i].is_br);
      br_seen = br_seen | dec[i].is_br;
    end
  end

  assign issue = iss;
  assign stall = rst_n & instr_vld[0] & ~iss[0];

  // Scoreboard next state: count down, then reload issuing destinations.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      if (iss[i] && dec[i].dst_vld && (int'(dec[i].dst) < NUM_REGS)) begin
        cnt_d[dec[i].dst[REG_W-1:0]] = CW'(LAT);
      end
    end
    cnt_d[0] = '0;
  end

  // Scoreboard counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Branch-shadow next state; flush takes priority over a branch issuing.
  always_comb begin
    state_d = state_q;
    shd_d   = shd_q;
    if (flush) begin
      state_d = SHD_OPEN;
      shd_d   = '0;
    end else begin
      case (state_q)
        SHD_OPEN: begin
          if (br_iss && (BR_SHADOW > 0)) begin
            state_d = SHD_SHADOW;
            shd_d   = SHW'(BR_SHADOW);
          end
        end
        SHD_SHADOW: begin
          shd_d = shd_q - SHW'(1);
          if (shd_q == SHW'(1)) state_d = SHD_OPEN;
        end
      endcase
    end
  end

  // Branch-shadow state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SHD_OPEN;
      shd_q   <= '0;
    end else begin
      state_q <= state_d;
      shd_q   <= shd_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  instr_vld;
  logic [63:0] instr;
  logic [1:0]  issue;
  logic        stall;
  logic [31:0] busy_regs;

  int checks   = 0;
  int failures = 0;

  hazard_scoreboard #(
    .LANES     (2),
    .NUM_REGS  (32),
    .REG_W     (5),
    .LAT       (3),
    .BR_SHADOW (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .instr_vld (instr_vld),
    .instr     (instr),
    .issue     (issue),
    .stall     (stall),
    .busy_regs (busy_regs)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt);
    return {6'(op), 5'(rs), 5'(rt), 16'd1};
  endfunction

  task automatic drive(input logic [1:0] v, input logic [31:0] i0,
                       input logic [31:0] i1, input logic fl);
    instr_vld = v;
    instr     = {i1, i0};
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_iss(input string tag, input logic [1:0] e_iss, input logic e_stall);
    checks++;
    assert (issue === e_iss) else begin
      failures++;
      $error("FAIL %s issue: got %b expected %b", tag, issue, e_iss);
    end
    checks++;
    assert (stall === e_stall) else begin
      failures++;
      $error("FAIL %s stall: got %b expected %b", tag, stall, e_stall);
    end
  endtask

  task automatic chk_busy(input string tag, input logic [31:0] e_busy);
    checks++;
    assert (busy_regs === e_busy) else begin
      failures++;
      $error("FAIL %s busy_regs: got %h expected %h", tag, busy_regs, e_busy);
    end
  endtask

  task automatic idle(input int n);
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    repeat (n) tick();
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b1;
    flush     = 1'b0;
    instr_vld = '0;
    instr     = '0;
    #1 rst_n = 1'b0;
    tick();

    // reset holds everything quiet even with a valid instruction presented
    drive(2'b01, rtype(1, 2, 3), 32'h0, 1'b0);
    chk_iss("reset", 2'b00, 1'b0);
    chk_busy("reset", 32'h0);
    tick();
    rst_n = 1'b1;

    // 1: RAW distance
    drive(2'b01, rtype(1, 2, 3), 32'h0, 1'b0);
    chk_iss("t1_prod", 2'b01, 1'b0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(2'b01, rtype(3, 1, 4), 32'h0, 1'b0);
      chk_iss($sformatf("t1_wait%0d", c), 2'b00, 1'b1);
      chk_busy($sformatf("t1_busy%0d", c), 32'h0000_0008);
      tick();
    end
    drive(2'b01, rtype(3, 1, 4), 32'h0, 1'b0);
    chk_iss("t1_go", 2'b01, 1'b0);
    chk_busy("t1_clear", 32'h0);
    tick();
    idle(4);

    // 2: intra-bundle RAW
    drive(2'b11, itype(8, 0, 5), rtype(5, 2, 6), 1'b0);
    chk_iss("t2_bundle", 2'b01, 1'b0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(2'b01, rtype(5, 2, 6), 32'h0, 1'b0);
      chk_iss($sformatf("t2_wait%0d", c), 2'b00, 1'b1);
      tick();
    end
    drive(2'b01, rtype(5, 2, 6), 32'h0, 1'b0);
    chk_iss("t2_go", 2'b01, 1'b0);
    tick();
    idle(4);

    // 3: branch shadow
    drive(2'b11, itype(4, 1, 2), rtype(1, 2, 9), 1'b0);
    chk_iss("t3_br", 2'b01, 1'b0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(2'b11, rtype(1, 2, 9), rtype(1, 2, 10), 1'b0);
      chk_iss($sformatf("t3_shadow%0d", c), 2'b00, 1'b1);
      tick();
    end
    drive(2'b11, rtype(1, 2, 9), rtype(1, 2, 10), 1'b0);
    chk_iss("t3_open", 2'b11, 1'b0);
    tick();
    idle(4);

    // 4: flush ends the shadow early, scoreboard untouched
    drive(2'b11, rtype(1, 2, 8), itype(4, 1, 2), 1'b0);
    chk_iss("t4_br", 2'b11, 1'b0);
    tick();
    drive(2'b01, rtype(1, 2, 11), 32'h0, 1'b1);
    chk_iss("t4_flushcyc", 2'b00, 1'b1);
    chk_busy("t4_busy1", 32'h0000_0100);
    tick();
    drive(2'b01, rtype(1, 2, 11), 32'h0, 1'b0);
    chk_iss("t4_resume", 2'b01, 1'b0);
    chk_busy("t4_busy2", 32'h0000_0100);
    tick();
    idle(4);

    // 5: $0 untracked, sw has no dst, WAW not a hazard
    drive(2'b01, rtype(1, 2, 0), 32'h0, 1'b0);
    chk_iss("t5_add0", 2'b01, 1'b0);
    tick();
    drive(2'b01, rtype(0, 0, 7), 32'h0, 1'b0);
    chk_iss("t5_add7", 2'b01, 1'b0);
    tick();
    drive(2'b01, itype(6'h2b, 1, 12), 32'h0, 1'b0);
    chk_iss("t5_sw", 2'b01, 1'b0);
    chk_busy("t5_zero_untracked", 32'h0000_0080);
    tick();
    drive(2'b01, itype(6'h23, 1, 12), 32'h0, 1'b0);
    chk_iss("t5_lw", 2'b01, 1'b0);
    tick();
    drive(2'b11, rtype(1, 2, 13), rtype(2, 1, 13), 1'b0);
    chk_iss("t5_waw", 2'b11, 1'b0);
    tick();
    drive(2'b01, rtype(13, 0, 14), 32'h0, 1'b0);
    chk_iss("t5_waw_dep", 2'b00, 1'b1);
    chk_busy("t5_busy", 32'h0000_3000);
    tick();
    idle(4);

    // 6: asynchronous reset mid-operation
    drive(2'b11, rtype(1, 2, 3), itype(4, 1, 2), 1'b0);
    chk_iss("t6_setup", 2'b11, 1'b0);
    tick();
    drive(2'b01, rtype(3, 1, 4), 32'h0, 1'b0);
    chk_iss("t6_blocked", 2'b00, 1'b1);
    tick();
    drive(2'b01, rtype(3, 1, 4), 32'h0, 1'b0);
    chk_busy("t6_pre", 32'h0000_0008);
    rst_n = 1'b0;
    #1;
    chk_iss("t6_rst", 2'b00, 1'b0);
    chk_busy("t6_rst", 32'h0);
    tick();
    rst_n = 1'b1;
    drive(2'b01, rtype(3, 1, 4), 32'h0, 1'b0);
    chk_iss("t6_release", 2'b01, 1'b0);
    chk_busy("t6_release", 32'h0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    chk_busy("t6_after", 32'h0000_0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
